seq_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_mul_iter.sv | 49 ++++
 rtl/seq_alu.sv | 182 ++++++++++++++++++
 tb/tb_seq_alu.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the flag bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_PASS_B = 4'd0,
    OP_PASS_A = 4'd1,
    OP_ADD    = 4'd2,
    OP_SUB    = 4'd3,
    OP_AND    = 4'd4,
    OP_OR     = 4'd5,
    OP_NOT    = 4'd6,
    OP_HOLD   = 4'd7,
    OP_XOR    = 4'd8,
    OP_SHL    = 4'd9,
    OP_SHR    = 4'd10,
    OP_SRA    = 4'd11,
    OP_MUL    = 4'd12
  } opc_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic err;
  } alu_flags_t;

  // Opcodes 13..15 are reserved and must never reach the last-result register.
  function automatic logic is_legal(input logic [3:0] op);
    return (op <= 4'd12);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles after start.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [CW-1:0]      cnt_r;

  // Load operands on start, then accumulate the shifted multiplicand per set multiplier bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      prod_r   <= {(2*WIDTH){1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else if (start) begin
      mcand_r  <= {{WIDTH{1'b0}}, a};
      mplier_r <= b;
      prod_r   <= {(2*WIDTH){1'b0}};
      cnt_r    <= CW'(WIDTH);
    end else if (cnt_r != {CW{1'b0}}) begin
      if (mplier_r[0]) begin
        prod_r <= prod_r + mcand_r;
      end
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r - CW'(1);
    end
  end

  // The owner only samples done while it is waiting on a started multiply.
  assign done    = (cnt_r == {CW{1'b0}});
  assign product = prod_r;

endmodule

// File: rtl/seq_alu.sv
// Handshaked WIDTH-bit ALU with registered result/flags, iterative multiply and hold-last-result.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_e             state_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [3:0]         opc_r;
  logic [WIDTH-1:0]   result_r;
  alu_flags_t         flags_r;
  logic               out_valid_r;
  logic               in_ready_r;
  logic [WIDTH-1:0]   last_res_r;
  alu_flags_t         last_flg_r;

  logic               mul_start_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] mul_prod_s;
  logic [WIDTH-1:0]   res_s;
  alu_flags_t         flg_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH-1:0]   dif_s;
  logic [SHW-1:0]     shamt_s;
  logic               big_shift_s;
  logic               carry_s;
  logic               ovf_s;
  logic               err_s;
  logic               hold_s;

  assign mul_start_s = (state_r == ST_IDLE) && in_valid && (opc == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_s),
    .a       (a),
    .b       (b),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  assign sum_s       = {1'b0, a_r} + {1'b0, b_r};
  assign dif_s       = b_r - a_r;
  assign shamt_s     = b_r[SHW-1:0];
  assign big_shift_s = |b_r[WIDTH-1:SHW];

  // Single-cycle datapath and flag generation from the latched operands.
  always_comb begin
    res_s   = {WIDTH{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    err_s   = 1'b0;
    hold_s  = 1'b0;
    case (opc_r)
      OP_PASS_B: res_s = b_r;
      OP_PASS_A: res_s = a_r;
      OP_ADD: begin
        res_s   = sum_s[WIDTH-1:0];
        carry_s = sum_s[WIDTH];
        ovf_s   = (a_r[MSB] == b_r[MSB]) && (sum_s[MSB] != a_r[MSB]);
      end
      OP_SUB: begin
        res_s   = dif_s;
        carry_s = (a_r > b_r);
        ovf_s   = (b_r[MSB] != a_r[MSB]) && (dif_s[MSB] != b_r[MSB]);
      end
      OP_AND:  res_s = a_r & b_r;
      OP_OR:   res_s = a_r | b_r;
      OP_NOT:  res_s = ~a_r;
      OP_HOLD: begin
        res_s  = last_res_r;
        hold_s = 1'b1;
      end
      OP_XOR:  res_s = a_r ^ b_r;
      OP_SHL:  res_s = big_shift_s ? {WIDTH{1'b0}} : (a_r << shamt_s);
      OP_SHR:  res_s = big_shift_s ? {WIDTH{1'b0}} : (a_r >> shamt_s);
      OP_SRA:  res_s = big_shift_s ? {WIDTH{a_r[MSB]}} : WIDTH'($signed(a_r) >>> shamt_s);
      OP_MUL: begin
        res_s   = mul_prod_s[WIDTH-1:0];
        carry_s = |mul_prod_s[2*WIDTH-1:WIDTH];
      end
      default: err_s = 1'b1;
    endcase
    if (hold_s) begin
      flg_s = last_flg_r;
    end else begin
      flg_s.zero  = (res_s == {WIDTH{1'b0}});
      flg_s.neg   = res_s[MSB];
      flg_s.carry = carry_s;
      flg_s.ovf   = ovf_s;
      flg_s.err   = err_s;
    end
  end

  // Handshake FSM; DONE spends its first cycle registering the result before raising out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      opc_r       <= 4'd0;
      result_r    <= {WIDTH{1'b0}};
      flags_r     <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      last_res_r  <= {WIDTH{1'b0}};
      last_flg_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b;
            opc_r      <= opc;
            in_ready_r <= 1'b0;
            state_r    <= (opc == OP_MUL) ? ST_BUSY : ST_DONE;
          end
        end
        ST_BUSY: begin
          if (mul_done_s) begin
            result_r    <= res_s;
            flags_r     <= flg_s;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!out_valid_r) begin
            result_r    <= res_s;
            flags_r     <= flg_s;
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
            if (is_legal(opc_r) && (opc_r != OP_HOLD)) begin
              last_res_r <= result_r;
              last_flg_r <= flags_r;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = flags_r.zero;
  assign neg       = flags_r.neg;
  assign carry     = flags_r.carry;
  assign ovf       = flags_r.ovf;
  assign err       = flags_r.err;

endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu at WIDTH=16 plus multi-cycle corner sequences.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  opc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero, neg, carry, ovf, err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  opc;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [4:0]  flg;   // {zero, neg, carry, ovf, err}
    int          lat;
  } vec_t;

  vec_t vecs[20];

  seq_alu #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opc       (opc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .neg       (neg),
    .carry     (carry),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op from a posedge+1 time point; returns cycles until out_valid (capped).
  task automatic do_op(input logic [3:0] o, input logic [15:0] va, input logic [15:0] vb,
                       output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    opc = o; a = va; b = vb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic deliver();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_deliver", {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  function automatic logic [4:0] flags_now();
    return {zero, neg, carry, ovf, err};
  endfunction

  initial begin
    int lat;
    vecs[0]  = '{4'd2,  16'hFFFF, 16'h0001, 16'h0000, 5'b10100, 1};
    vecs[1]  = '{4'd3,  16'h0001, 16'h8000, 16'h7FFF, 5'b00010, 1};
    vecs[2]  = '{4'd11, 16'h8000, 16'd20,   16'hFFFF, 5'b01000, 1};
    vecs[3]  = '{4'd8,  16'h00FF, 16'h0F0F, 16'h0FF0, 5'b00000, 1};
    vecs[4]  = '{4'd0,  16'h0001, 16'h8000, 16'h8000, 5'b01000, 1};
    vecs[5]  = '{4'd1,  16'h1234, 16'h0000, 16'h1234, 5'b00000, 1};
    vecs[6]  = '{4'd4,  16'hF0F0, 16'h3C3C, 16'h3030, 5'b00000, 1};
    vecs[7]  = '{4'd5,  16'h0F00, 16'h00F0, 16'h0FF0, 5'b00000, 1};
    vecs[8]  = '{4'd6,  16'hFFFF, 16'h1234, 16'h0000, 5'b10000, 1};
    vecs[9]  = '{4'd9,  16'h0001, 16'd15,   16'h8000, 5'b01000, 1};
    vecs[10] = '{4'd9,  16'h0001, 16'd16,   16'h0000, 5'b10000, 1};
    vecs[11] = '{4'd10, 16'h8000, 16'd4,    16'h0800, 5'b00000, 1};
    vecs[12] = '{4'd10, 16'h8000, 16'd16,   16'h0000, 5'b10000, 1};
    vecs[13] = '{4'd11, 16'h8000, 16'd4,    16'hF800, 5'b01000, 1};
    vecs[14] = '{4'd2,  16'h7FFF, 16'h0001, 16'h8000, 5'b01010, 1};
    vecs[15] = '{4'd3,  16'h0005, 16'h0003, 16'hFFFE, 5'b01100, 1};
    vecs[16] = '{4'd12, 16'h0100, 16'h0101, 16'h0100, 5'b00100, 17};
    vecs[17] = '{4'd12, 16'h00FF, 16'h0003, 16'h02FD, 5'b00000, 17};
    vecs[18] = '{4'd13, 16'h1111, 16'h2222, 16'h0000, 5'b10001, 1};
    vecs[19] = '{4'd7,  16'hAAAA, 16'h5555, 16'h02FD, 5'b00000, 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 16'h0000; b = 16'h0000; opc = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {in_ready, out_valid, flags_now(), result}, {1'b1, 1'b0, 5'b00000, 16'h0000});
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_op(vecs[i].opc, vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_result", i), {16'd0, result}, {16'd0, vecs[i].res});
      check($sformatf("vec%0d_flags", i), {27'd0, flags_now()}, {27'd0, vecs[i].flg});
      deliver();
    end

    // MUL with stray in_valid pulses while busy: must be ignored and in_ready must stay low.
    opc = 4'd12; a = 16'h0100; b = 16'h0101; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 100) begin
      check("mul_busy_ready", {31'd0, in_ready}, 32'd0);
      in_valid = lat[0];
      opc = 4'd1; a = 16'hFFFF;
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    check("mul_pulse_latency", lat, 17);
    check("mul_pulse_result", {11'd0, result, flags_now()}, {11'd0, 16'h0100, 5'b00100});
    deliver();

    // Back-pressure: outputs frozen for 5 cycles of out_ready low.
    do_op(4'd8, 16'h00FF, 16'h0F0F, lat);
    for (int k = 0; k < 5; k++) begin
      check("bp_hold", {9'd0, out_valid, in_ready, result, flags_now()},
            {9'd0, 1'b1, 1'b0, 16'h0FF0, 5'b00000});
      @(posedge clk); #1;
    end
    deliver();

    // ADD 3+4, then illegal opcode, then HOLD re-emits the ADD result.
    do_op(4'd2, 16'h0003, 16'h0004, lat);
    check("add34", {11'd0, result, flags_now()}, {11'd0, 16'h0007, 5'b00000});
    deliver();
    do_op(4'd14, 16'h0003, 16'h0004, lat);
    check("illegal14", {11'd0, result, flags_now()}, {11'd0, 16'h0000, 5'b10001});
    deliver();
    do_op(4'd7, 16'h0000, 16'h0000, lat);
    check("hold_after_illegal", {11'd0, result, flags_now()}, {11'd0, 16'h0007, 5'b00000});
    deliver();

    // Reset during the 5th BUSY cycle of a MUL aborts immediately.
    opc = 4'd12; a = 16'h0100; b = 16'h0101; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("mul_busy_before_reset", {30'd0, in_ready, out_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_reset", {in_ready, out_valid, result}, {1'b1, 1'b0, 16'h0000});
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(4'd1, 16'h1234, 16'h0000, lat);
    check("post_reset_latency", lat, 1);
    check("post_reset_pass_a", {11'd0, result, flags_now()}, {11'd0, 16'h1234, 5'b00000});
    deliver();
    do_op(4'd7, 16'h0000, 16'h0000, lat);
    check("hold_after_reset", {11'd0, result, flags_now()}, {11'd0, 16'h1234, 5'b00000});
    deliver();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
